// File: rtl/instr_fetch_mem.sv
// Instruction memory with a valid/ready fetch port, fixed-latency read pipeline,
// in-order response FIFO with credit flow control, flush, and a program-load port.
module instr_fetch_mem #(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DEPTH     = 2**ADDR_W,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned RSP_DEPTH = READ_LAT + 1
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] reqAddr,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [DATA_W-1:0] rspData,
  output logic [ADDR_W-1:0] rspAddr,
  output logic              rspErr,
  input  logic              flush,
  input  logic              ldEn,
  input  logic [ADDR_W-1:0] ldAddr,
  input  logic [DATA_W-1:0] ldData
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(READ_LAT + RSP_DEPTH + 1);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [READ_LAT-1:0] pipe_valid;
  logic [READ_LAT-1:0] pipe_err;
  logic [DATA_W-1:0]   pipe_data [READ_LAT];
  logic [ADDR_W-1:0]   pipe_addr [READ_LAT];

  logic [RSP_DEPTH-1:0] buf_err;
  logic [DATA_W-1:0]    buf_data [RSP_DEPTH];
  logic [ADDR_W-1:0]    buf_addr [RSP_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic              req_in_range_c;
  logic              ld_in_range_c;
  logic [OUT_W-1:0]  inflight_c;
  logic [OUT_W-1:0]  outstanding_c;
  logic              pop_c;
  logic              push_c;
  logic              accept_c;
  logic [DATA_W-1:0] rd_word_c;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: a pop this cycle frees its slot for a same-cycle accept.
  always_comb begin
    req_in_range_c = ({1'b0, reqAddr} < DEPTH_EXT);
    ld_in_range_c  = ({1'b0, ldAddr} < DEPTH_EXT);
    inflight_c     = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight_c = inflight_c + OUT_W'(pipe_valid[i]);
    end
    pop_c         = rspValid && rspReady;
    push_c        = pipe_valid[READ_LAT-1];
    outstanding_c = inflight_c + OUT_W'(count) - OUT_W'(pop_c);
    reqReady      = rstN && !ldEn && !flush && (outstanding_c < OUT_W'(RSP_DEPTH));
    accept_c      = reqValid && reqReady;
    rd_word_c     = req_in_range_c ? mem[reqAddr[IDX_W-1:0]] : '0;
  end

  // Program-load write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (ldEn && ld_in_range_c) begin
      mem[ldAddr[IDX_W-1:0]] <= ldData;
    end
  end

  // Read pipeline: stage 0 captures the word in the accept cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_data[i] <= '0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept_c;
      if (accept_c) begin
        pipe_data[0] <= rd_word_c;
        pipe_addr[0] <= reqAddr;
        pipe_err[0]  <= !req_in_range_c;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] && !flush;
        pipe_data[i]  <= pipe_data[i-1];
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  // Response FIFO; flush drops everything including a same-cycle push.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      buf_err <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_addr[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        buf_data[wr_ptr] <= pipe_data[READ_LAT-1];
        buf_addr[wr_ptr] <= pipe_addr[READ_LAT-1];
        buf_err[wr_ptr]  <= pipe_err[READ_LAT-1];
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop_c) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  assign rspValid = (count != '0);
  assign rspData  = buf_data[rd_ptr];
  assign rspAddr  = buf_addr[rd_ptr];
  assign rspErr   = buf_err[rd_ptr];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed plus randomized bench for instr_fetch_mem against a queue-based
// reference model of in-order responses with fixed arrival latency.
module tb_instr_fetch_mem;

  localparam int unsigned DATA_W    = 18;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned RSP_DEPTH = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;
  logic              flush;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  instr_fetch_mem #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rstN(rst_n),
    .reqValid(req_valid), .reqReady(req_ready), .reqAddr(req_addr),
    .rspValid(rsp_valid), .rspReady(rsp_ready), .rspData(rsp_data),
    .rspAddr(rsp_addr), .rspErr(rsp_err),
    .flush(flush), .ldEn(ld_en), .ldAddr(ld_addr), .ldData(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              err;
    int                due;
  } exp_t;

  exp_t              q[$];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                cyc;
  int                n_tests;
  int                n_fail;
  int                pops;
  int                accepts;
  logic [DATA_W-1:0] last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance the model at the edge.
  task automatic tick();
    logic exp_valid, pop, acc, exp_ready;
    int   occ;
    exp_t e;
    if (!rst_n) q.delete();
    #1;
    exp_valid = 1'b0;
    if (rst_n && q.size() > 0) exp_valid = (q[0].due <= cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
      chk("rsp_addr", 32'(rsp_addr), 32'(q[0].addr));
      chk("rsp_err",  32'(rsp_err),  32'(q[0].err));
    end
    pop = exp_valid && rsp_ready;
    occ = q.size() - (pop ? 1 : 0);
    exp_ready = rst_n && !ld_en && !flush && (occ < int'(RSP_DEPTH));
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = req_valid && exp_ready;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (pop) begin
        last_pop = q[0].data;
        pops++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      if (acc) begin
        accepts++;
        e.addr = req_addr;
        e.err  = (req_addr >= ADDR_W'(DEPTH));
        e.data = e.err ? '0 : ref_mem[req_addr[3:0]];
        e.due  = cyc + int'(READ_LAT);
        q.push_back(e);
      end
      if (ld_en && ld_addr < ADDR_W'(DEPTH)) ref_mem[ld_addr[3:0]] = ld_data;
    end
    @(negedge clk);
  endtask

  task automatic fetch(input int a);
    req_valid = 1'b1;
    req_addr  = ADDR_W'(a);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int p0, a0;
    cyc = 0; n_tests = 0; n_fail = 0; pops = 0; accepts = 0; last_pop = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data",  32'(rsp_data),  32'd0);
    chk("reset_rsp_addr",  32'(rsp_addr),  32'd0);
    chk("reset_rsp_err",   32'(rsp_err),   32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program image: words 0..3 fixed, remainder random.
    for (int a = 0; a < int'(DEPTH); a++) begin
      ld_en   = 1'b1;
      ld_addr = ADDR_W'(a);
      ld_data = (a < 4) ? DATA_W'((a + 1) * 'h11) : DATA_W'($urandom);
      tick();
    end
    ld_en = 1'b0;

    // Back-to-back fetches with the consumer always ready.
    rsp_ready = 1'b1;
    a0 = accepts; p0 = pops;
    for (int a = 0; a < 4; a++) fetch(a);
    idle(READ_LAT + 3);
    chk("t1_accepts", 32'(accepts - a0), 32'd4);
    chk("t1_pops", 32'(pops - p0), 32'd4);
    chk("t1_last", 32'(last_pop), 32'h44);

    // Backpressure: credits run out after RSP_DEPTH accepts.
    rsp_ready = 1'b0;
    a0 = accepts; p0 = pops;
    for (int i = 0; i < 8; i++) fetch(i % 4);
    chk("t2_accepts", 32'(accepts - a0), 32'(RSP_DEPTH));
    rsp_ready = 1'b1;
    idle(8);
    chk("t2_pops", 32'(pops - p0), 32'(RSP_DEPTH));

    // Load blocks fetch for that cycle; subsequent fetch sees new word.
    p0 = pops;
    ld_en = 1'b1; ld_addr = ADDR_W'(5); ld_data = DATA_W'('h3FFFF);
    req_valid = 1'b1; req_addr = ADDR_W'(5);
    tick();
    ld_en = 1'b0;
    fetch(5);
    idle(READ_LAT + 3);
    chk("t3_pops", 32'(pops - p0), 32'd1);
    chk("t3_data", 32'(last_pop), 32'h3FFFF);

    // Out-of-range fetch between two good ones.
    p0 = pops;
    fetch(1); fetch(20); fetch(2);
    idle(READ_LAT + 3);
    chk("t4_pops", 32'(pops - p0), 32'd3);
    chk("t4_last", 32'(last_pop), 32'h33);

    // Flush with two in flight; only the later fetch returns.
    rsp_ready = 1'b0;
    fetch(0); fetch(1);
    flush = 1'b1; tick(); flush = 1'b0;
    rsp_ready = 1'b1;
    p0 = pops;
    fetch(3);
    idle(READ_LAT + 3);
    chk("t5_pops", 32'(pops - p0), 32'd1);
    chk("t5_data", 32'(last_pop), 32'h44);

    // Reset with work outstanding.
    rsp_ready = 1'b0;
    fetch(0); fetch(1); idle(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid_async", 32'(rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    p0 = pops;
    idle(4);
    chk("t6_no_ghost", 32'(pops - p0), 32'd0);
    fetch(1);
    idle(READ_LAT + 3);
    chk("t6_pops", 32'(pops - p0), 32'd1);
    chk("t6_data", 32'(last_pop), 32'h22);

    // Randomized traffic with loads, flushes, out-of-range and resets.
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ADDR_W'($urandom_range(0, 19));
      rsp_ready = ($urandom_range(0, 2) != 0);
      ld_en     = ($urandom_range(0, 15) == 0);
      ld_addr   = ADDR_W'($urandom_range(0, 19));
      ld_data   = DATA_W'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      if (!rst_n) begin
        ld_en = 1'b0;
        flush = 1'b0;
      end
      tick();
      rst_n = 1'b1;
    end
    flush = 1'b0; ld_en = 1'b0; rsp_ready = 1'b1;
    idle(RSP_DEPTH + READ_LAT + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
